// File: rtl/rx_fifo_if.sv
// Bundles the receive-side push strobe, the FWFT read port and the status outputs of rx_fifo.
interface rx_fifo_if #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int FIFO_DEPTH      = 16
);
  localparam int AddrWidth = $clog2(FIFO_DEPTH);

  logic                       rx_done_i;
  logic                       rx_parity_err_i;
  logic [MAX_UART_DATA_W-1:0] rx_data_i;
  logic                       clr_i;
  logic                       rd_ready_i;
  logic                       rd_valid_o;
  logic [MAX_UART_DATA_W-1:0] rd_data_o;
  logic                       rd_parity_err_o;
  logic [AddrWidth:0]         level_o;
  logic                       full_o;
  logic                       empty_o;
  logic                       overflow_o;

  modport master (
    output rx_done_i, rx_parity_err_i, rx_data_i, clr_i, rd_ready_i,
    input  rd_valid_o, rd_data_o, rd_parity_err_o, level_o, full_o, empty_o, overflow_o
  );

  modport slave (
    input  rx_done_i, rx_parity_err_i, rx_data_i, clr_i, rd_ready_i,
    output rd_valid_o, rd_data_o, rd_parity_err_o, level_o, full_o, empty_o, overflow_o
  );
endinterface

// File: rtl/rx_fifo.sv
// First-word-fall-through character FIFO between the UART receive stage and the host side.
// Each rising edge of rx_done_i stores one {parity_err, data} entry; a sticky flag records drops.
module rx_fifo #(
  parameter int MAX_UART_DATA_W = 8,
  parameter int FIFO_DEPTH      = 16
) (
  input logic      clk_i,
  input logic      rst_i,
  rx_fifo_if.slave bus
);
  localparam int AddrWidth = $clog2(FIFO_DEPTH);
  localparam int LvlW      = AddrWidth + 1;
  localparam int EntryW    = MAX_UART_DATA_W + 1;
  localparam logic [LvlW-1:0] DepthLvl = FIFO_DEPTH[LvlW-1:0];

  logic [EntryW-1:0]    mem_q [FIFO_DEPTH];
  logic [AddrWidth-1:0] wr_ptr_q, wr_ptr_d;
  logic [AddrWidth-1:0] rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]      level_q, level_d;
  logic                 overflow_q, overflow_d;
  logic                 rx_done_q;

  logic              push_s, pop_s, wr_en_s, full_s, empty_s;
  logic [EntryW-1:0] head_s;

  assign empty_s = (level_q == {LvlW{1'b0}});
  assign full_s  = (level_q == DepthLvl);
  assign push_s  = bus.rx_done_i & ~rx_done_q;
  assign pop_s   = ~empty_s & bus.rd_ready_i;
  // A push into a full FIFO is only accepted when the head leaves in the same cycle.
  assign wr_en_s = push_s & (~full_s | pop_s) & ~bus.clr_i & ~rst_i;
  assign head_s  = mem_q[rd_ptr_q];

  // Next-state for pointers, level and sticky overflow; clear outranks push/pop.
  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    level_d    = level_q;
    overflow_d = overflow_q;
    if (bus.clr_i) begin
      wr_ptr_d   = {AddrWidth{1'b0}};
      rd_ptr_d   = {AddrWidth{1'b0}};
      level_d    = {LvlW{1'b0}};
      overflow_d = 1'b0;
    end else begin
      if (wr_en_s) begin
        wr_ptr_d = wr_ptr_q + AddrWidth'(1);
      end else begin
        wr_ptr_d = wr_ptr_q;
      end
      if (pop_s) begin
        rd_ptr_d = rd_ptr_q + AddrWidth'(1);
      end else begin
        rd_ptr_d = rd_ptr_q;
      end
      case ({wr_en_s, pop_s})
        2'b10:   level_d = level_q + LvlW'(1);
        2'b01:   level_d = level_q - LvlW'(1);
        default: level_d = level_q;
      endcase
      if (push_s & full_s & ~pop_s) begin
        overflow_d = 1'b1;
      end else begin
        overflow_d = overflow_q;
      end
    end
  end

  // State registers; the edge detector tracks rx_done_i even in reset so a held strobe never re-pushes.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q   <= {AddrWidth{1'b0}};
      rd_ptr_q   <= {AddrWidth{1'b0}};
      level_q    <= {LvlW{1'b0}};
      overflow_q <= 1'b0;
      rx_done_q  <= bus.rx_done_i;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      overflow_q <= overflow_d;
      rx_done_q  <= bus.rx_done_i;
    end
  end

  // Storage array, intentionally left unreset.
  always_ff @(posedge clk_i) begin
    if (wr_en_s) begin
      mem_q[wr_ptr_q] <= {bus.rx_parity_err_i, bus.rx_data_i};
    end
  end

  assign bus.rd_valid_o      = ~empty_s;
  assign bus.rd_data_o       = empty_s ? {MAX_UART_DATA_W{1'b0}} : head_s[MAX_UART_DATA_W-1:0];
  assign bus.rd_parity_err_o = empty_s ? 1'b0 : head_s[EntryW-1];
  assign bus.level_o         = level_q;
  assign bus.full_o          = full_s;
  assign bus.empty_o         = empty_s;
  assign bus.overflow_o      = overflow_q;
endmodule

// File: tb/tb_rx_fifo.sv
// Directed-plus-random bench for rx_fifo, compared every cycle against a queue-based reference model.
module tb_rx_fifo;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   failures = 0;
  bit   rand_ready = 1'b0;

  logic [8:0] q[$];
  bit         m_ovf  = 1'b0;
  bit         m_prev = 1'b0;

  always #5 clk = ~clk;

  rx_fifo_if #(.MAX_UART_DATA_W(8), .FIFO_DEPTH(16)) bus ();

  rx_fifo #(.MAX_UART_DATA_W(8), .FIFO_DEPTH(16)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: optional random ready, model update from the sampled inputs, then full output compare.
  task automatic cycle();
    bit push, pop, was_full;
    logic [7:0] exp_data;
    logic       exp_perr;
    if (rand_ready) bus.rd_ready_i = 1'($urandom_range(0, 1));
    @(posedge clk);
    if (rst) begin
      q.delete();
      m_ovf  = 1'b0;
      m_prev = bus.rx_done_i;
    end else begin
      push     = bus.rx_done_i && !m_prev;
      pop      = (q.size() != 0) && bus.rd_ready_i;
      was_full = (q.size() == 16);
      if (bus.clr_i) begin
        q.delete();
        m_ovf = 1'b0;
      end else begin
        if (pop) void'(q.pop_front());
        if (push) begin
          if (!was_full || pop) q.push_back({bus.rx_parity_err_i, bus.rx_data_i});
          else m_ovf = 1'b1;
        end
      end
      m_prev = bus.rx_done_i;
    end
    #1;
    exp_data = (q.size() != 0) ? q[0][7:0] : 8'h00;
    exp_perr = (q.size() != 0) ? q[0][8] : 1'b0;
    check("level", 32'(bus.level_o), 32'(q.size()));
    check("rd_valid", 32'(bus.rd_valid_o), 32'(q.size() != 0));
    check("rd_data", 32'(bus.rd_data_o), 32'(exp_data));
    check("rd_perr", 32'(bus.rd_parity_err_o), 32'(exp_perr));
    check("full", 32'(bus.full_o), 32'(q.size() == 16));
    check("empty", 32'(bus.empty_o), 32'(q.size() == 0));
    check("overflow", 32'(bus.overflow_o), 32'(m_ovf));
  endtask

  task automatic push_char(input logic [7:0] d, input logic p, input int hold);
    bus.rx_data_i       = d;
    bus.rx_parity_err_i = p;
    bus.rx_done_i       = 1'b1;
    repeat (hold) cycle();
    bus.rx_done_i = 1'b0;
    bus.rx_data_i = 8'($urandom);
    cycle();
  endtask

  task automatic drain(input int n);
    bus.rd_ready_i = 1'b1;
    repeat (n) cycle();
    bus.rd_ready_i = 1'b0;
  endtask

  initial begin
    bus.rx_done_i       = 1'b0;
    bus.rx_parity_err_i = 1'b0;
    bus.rx_data_i       = 8'h00;
    bus.clr_i           = 1'b0;
    bus.rd_ready_i      = 1'b0;

    // Reset state.
    repeat (3) cycle();
    rst = 1'b0;
    cycle();
    check("rst_level", 32'(bus.level_o), 32'd0);
    check("rst_empty", 32'(bus.empty_o), 32'd1);
    check("rst_full", 32'(bus.full_o), 32'd0);
    check("rst_valid", 32'(bus.rd_valid_o), 32'd0);
    check("rst_data", 32'(bus.rd_data_o), 32'd0);
    check("rst_ovf", 32'(bus.overflow_o), 32'd0);

    // Single character with a long rx_done pulse.
    push_char(8'hA5, 1'b0, 16);
    check("single_level", 32'(bus.level_o), 32'd1);
    check("single_data", 32'(bus.rd_data_o), 32'hA5);
    drain(1);
    check("single_empty", 32'(bus.empty_o), 32'd1);
    check("single_data0", 32'(bus.rd_data_o), 32'd0);
    drain(2);

    // Fill past capacity.
    for (int i = 0; i < 17; i++) push_char(8'(i), 1'($urandom_range(0, 1)), $urandom_range(2, 6));
    check("fill_full", 32'(bus.full_o), 32'd1);
    check("fill_ovf", 32'(bus.overflow_o), 32'd1);
    check("fill_head", 32'(bus.rd_data_o), 32'd0);
    drain(16);
    check("drain_ovf_sticky", 32'(bus.overflow_o), 32'd1);
    check("drain_empty", 32'(bus.empty_o), 32'd1);
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    cycle();
    check("clr_ovf", 32'(bus.overflow_o), 32'd0);

    // Interleaved push/pop with random ready across pointer wrap.
    rand_ready = 1'b1;
    for (int i = 0; i < 40; i++) push_char(8'($urandom), 1'($urandom_range(0, 1)), $urandom_range(2, 4));
    rand_ready = 1'b0;
    drain(20);
    check("wrap_empty", 32'(bus.empty_o), 32'd1);

    // Full with simultaneous push and pop.
    for (int i = 0; i < 16; i++) push_char(8'($urandom_range(0, 8'h54)), 1'b0, 2);
    check("sim_full", 32'(bus.full_o), 32'd1);
    bus.rx_data_i  = 8'h55;
    bus.rx_done_i  = 1'b1;
    bus.rd_ready_i = 1'b1;
    cycle();
    bus.rd_ready_i = 1'b0;
    repeat (3) cycle();
    bus.rx_done_i = 1'b0;
    cycle();
    check("sim_level", 32'(bus.level_o), 32'd16);
    check("sim_ovf", 32'(bus.overflow_o), 32'd0);
    drain(15);
    check("sim_last", 32'(bus.rd_data_o), 32'h55);
    drain(1);

    // Parity flag storage.
    push_char(8'h3C, 1'b1, 3);
    push_char(8'hC3, 1'b0, 3);
    check("par_first", 32'(bus.rd_parity_err_o), 32'd1);
    drain(1);
    check("par_second", 32'(bus.rd_parity_err_o), 32'd0);
    check("par_data", 32'(bus.rd_data_o), 32'hC3);
    drain(1);

    // Clear at level 5 with rx_done held high.
    for (int i = 0; i < 4; i++) push_char(8'($urandom), 1'b0, 2);
    bus.rx_data_i = 8'h77;
    bus.rx_done_i = 1'b1;
    cycle();
    check("clr_pre_level", 32'(bus.level_o), 32'd5);
    bus.clr_i = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    repeat (4) cycle();
    check("clr_level", 32'(bus.level_o), 32'd0);
    bus.rx_done_i = 1'b0;
    cycle();
    // Clear coinciding with a rising edge discards that push.
    bus.rx_done_i = 1'b1;
    bus.clr_i     = 1'b1;
    cycle();
    bus.clr_i = 1'b0;
    repeat (3) cycle();
    check("clr_edge_level", 32'(bus.level_o), 32'd0);
    bus.rx_done_i = 1'b0;
    cycle();

    // Reset mid-fill with rx_done held across release.
    for (int i = 0; i < 3; i++) push_char(8'($urandom), 1'b1, 2);
    bus.rx_done_i = 1'b1;
    cycle();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    check("mid_rst_level", 32'(bus.level_o), 32'd0);
    check("mid_rst_valid", 32'(bus.rd_valid_o), 32'd0);
    repeat (4) cycle();
    check("mid_rst_nopush", 32'(bus.level_o), 32'd0);
    bus.rx_done_i = 1'b0;
    cycle();
    push_char(8'h9E, 1'b0, 3);
    check("post_rst_push", 32'(bus.rd_data_o), 32'h9E);
    drain(2);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
